// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC sequencing, one-deep hold buffer for decode stalls, redirect flush.
// Optional misaligned-redirect pulse enabled by defining FETCH_MISALIGN_CHECK_EN.
module instruction_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_INSTRUCTION,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic [31:0] IF_INSTR,
  output logic [31:0] IF_PC,
  output logic        IF_VALID,
  output logic        MISALIGN_ERR
);

  logic [31:0] pc_q,         pc_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_pc_q,    resp_pc_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q,    hold_pc_d;

  logic [31:0] redirect_pc_s;
  logic        advance_s;
  logic        out_valid_s;

  // Redirect targets are forced to a word boundary; the low bits only feed the optional check.
  assign redirect_pc_s = REDIRECT_PC & 32'hFFFF_FFFC;

  // PC may advance when decode is taking data, or when nothing is fetched or buffered yet.
  assign advance_s = (!STALL) || (!hold_valid_q && !resp_valid_q);

  // Next-state: PC priority, in-flight tracking, hold buffer capture/release.
  always_comb begin
    pc_d         = pc_q;
    resp_pc_d    = pc_q;
    resp_valid_d = !REDIRECT;
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    if (REDIRECT) begin
      pc_d         = redirect_pc_s;
      hold_valid_d = 1'b0;
    end else begin
      if (advance_s) begin
        pc_d = pc_q + 32'd4;
      end else begin
        pc_d = pc_q;
      end
      if (hold_valid_q) begin
        if (!STALL) begin
          hold_valid_d = 1'b0;
        end else begin
          hold_valid_d = 1'b1;
        end
      end else if (STALL && resp_valid_q) begin
        hold_valid_d = 1'b1;
        hold_instr_d = IMEM_INSTRUCTION;
        hold_pc_d    = resp_pc_q;
      end else begin
        hold_valid_d = 1'b0;
      end
    end
  end

  // Fetch state registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc_q         <= RESET_VECTOR;
      resp_valid_q <= 1'b0;
      resp_pc_q    <= 32'h0000_0000;
      hold_valid_q <= 1'b0;
      hold_instr_q <= 32'h0000_0000;
      hold_pc_q    <= 32'h0000_0000;
    end else begin
      pc_q         <= pc_d;
      resp_valid_q <= resp_valid_d;
      resp_pc_q    <= resp_pc_d;
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  assign IMEM_ADDR   = pc_q;
  assign out_valid_s = !REDIRECT && (hold_valid_q || resp_valid_q);

  // Output mux: buffered entry wins; zero payload whenever not valid.
  always_comb begin
    IF_VALID = out_valid_s;
    IF_INSTR = 32'h0000_0000;
    IF_PC    = 32'h0000_0000;
    if (out_valid_s) begin
      if (hold_valid_q) begin
        IF_INSTR = hold_instr_q;
        IF_PC    = hold_pc_q;
      end else begin
        IF_INSTR = IMEM_INSTRUCTION;
        IF_PC    = resp_pc_q;
      end
    end else begin
      IF_INSTR = 32'h0000_0000;
      IF_PC    = 32'h0000_0000;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign misalign_d = REDIRECT && (REDIRECT_PC[1:0] != 2'b00);

  // One-cycle pulse after a redirect whose target was not word aligned.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign MISALIGN_ERR = misalign_q;
`else
  assign MISALIGN_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: expected accepted PCs are queued with the stimulus
// and popped whenever decode accepts an instruction (IF_VALID=1, STALL=0).
module tb_instruction_fetch;

  logic        clk_s = 1'b0;
  logic        reset_n_s;
  logic [31:0] imem_addr_s;
  logic [31:0] imem_data_s;
  logic        stall_s;
  logic        redirect_s;
  logic [31:0] redirect_pc_s;
  logic [31:0] if_instr_s;
  logic [31:0] if_pc_s;
  logic        if_valid_s;
  logic        misalign_s;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic EXP_MIS = 1'b1;
`else
  localparam logic EXP_MIS = 1'b0;
`endif

  instruction_fetch #(.RESET_VECTOR(32'h0000_0000)) dut (
    .CLK              (clk_s),
    .RESET            (reset_n_s),
    .IMEM_ADDR        (imem_addr_s),
    .IMEM_INSTRUCTION (imem_data_s),
    .STALL            (stall_s),
    .REDIRECT         (redirect_s),
    .REDIRECT_PC      (redirect_pc_s),
    .IF_INSTR         (if_instr_s),
    .IF_PC            (if_pc_s),
    .IF_VALID         (if_valid_s),
    .MISALIGN_ERR     (misalign_s)
  );

  always #5 clk_s = ~clk_s;

  function automatic logic [31:0] word_of(input logic [31:0] addr);
    return 32'h1000_0000 + {2'b00, addr[31:2]};
  endfunction

  // Synchronous-read instruction memory: data valid the cycle after the address is sampled.
  always @(posedge clk_s) imem_data_s <= word_of(imem_addr_s);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  // Scoreboard monitor plus per-cycle protocol rules.
  always @(negedge clk_s) begin
    if (reset_n_s === 1'b1) begin
      if (redirect_s) check_val("valid_in_redirect", {31'd0, if_valid_s}, 32'd0);
      if (!if_valid_s) begin
        check_val("idle_pc_zero", if_pc_s, 32'd0);
        check_val("idle_instr_zero", if_instr_s, 32'd0);
      end
      if (if_valid_s && !stall_s) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_accept", if_pc_s, 32'hFFFF_FFFF);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check_val("sb_pc", if_pc_s, e);
          check_val("sb_instr", if_instr_s, word_of(e));
        end
      end
    end
  end

  task automatic cyc(input logic st, input logic rd, input logic [31:0] rpc);
    @(posedge clk_s);
    #1;
    stall_s       = st;
    redirect_s    = rd;
    redirect_pc_s = rpc;
    @(negedge clk_s);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc);
    check_val({tag, "_valid"}, {31'd0, if_valid_s}, {31'd0, v});
    if (v) begin
      check_val({tag, "_pc"}, if_pc_s, pc);
      check_val({tag, "_instr"}, if_instr_s, word_of(pc));
    end else begin
      check_val({tag, "_pc0"}, if_pc_s, 32'd0);
    end
  endtask

  initial begin
    reset_n_s     = 1'b1;
    stall_s       = 1'b0;
    redirect_s    = 1'b0;
    redirect_pc_s = 32'd0;
    #3 reset_n_s  = 1'b0;
    repeat (2) @(posedge clk_s);
    @(negedge clk_s);
    check_val("rst_addr", imem_addr_s, 32'h0);
    check_val("rst_valid", {31'd0, if_valid_s}, 32'd0);
    check_val("rst_instr", if_instr_s, 32'd0);
    check_val("rst_pc", if_pc_s, 32'd0);
    check_val("rst_mis", {31'd0, misalign_s}, 32'd0);

    @(posedge clk_s);
    #1 reset_n_s = 1'b1;
    @(negedge clk_s);
    chk_out("release", 1'b0, 32'd0);
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(32'h0);  exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);  exp_q.push_back(32'hC);

    cyc(1'b0, 1'b0, 32'd0); chk_out("seq0", 1'b1, 32'h0);
    cyc(1'b0, 1'b0, 32'd0); chk_out("seq1", 1'b1, 32'h4);
    cyc(1'b1, 1'b0, 32'd0); chk_out("stall_a", 1'b1, 32'h8);
    cyc(1'b1, 1'b0, 32'd0); chk_out("stall_b", 1'b1, 32'h8);
    cyc(1'b1, 1'b0, 32'd0); chk_out("stall_c", 1'b1, 32'h8);
    cyc(1'b0, 1'b0, 32'd0); chk_out("stall_rel", 1'b1, 32'h8);
    cyc(1'b0, 1'b0, 32'd0); chk_out("post_stall", 1'b1, 32'hC);

    exp_q.push_back(32'h40); exp_q.push_back(32'h44);
    cyc(1'b0, 1'b1, 32'h40); chk_out("redir", 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 32'd0);  chk_out("bubble", 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 32'd0);  chk_out("tgt40", 1'b1, 32'h40);
    cyc(1'b0, 1'b0, 32'd0);  chk_out("tgt44", 1'b1, 32'h44);

    exp_q.push_back(32'h20); exp_q.push_back(32'h24); exp_q.push_back(32'h28);
    cyc(1'b0, 1'b1, 32'h20); chk_out("redir20", 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 32'd0);  chk_out("rs_stall1", 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 32'd0);  chk_out("rs_stall2", 1'b1, 32'h20);
    cyc(1'b0, 1'b0, 32'd0);  chk_out("rs_rel", 1'b1, 32'h20);
    cyc(1'b0, 1'b0, 32'd0);  chk_out("rs_24", 1'b1, 32'h24);
    cyc(1'b0, 1'b0, 32'd0);  chk_out("rs_28", 1'b1, 32'h28);

    exp_q.push_back(32'h20); exp_q.push_back(32'h24);
    cyc(1'b0, 1'b1, 32'h22); chk_out("mis_redir", 1'b0, 32'd0);
    check_val("mis_same_cycle", {31'd0, misalign_s}, 32'd0);
    cyc(1'b0, 1'b0, 32'd0);  chk_out("mis_bubble", 1'b0, 32'd0);
    check_val("mis_pulse", {31'd0, misalign_s}, {31'd0, EXP_MIS});
    cyc(1'b0, 1'b0, 32'd0);  chk_out("mis_20", 1'b1, 32'h20);
    check_val("mis_after", {31'd0, misalign_s}, 32'd0);
    cyc(1'b0, 1'b0, 32'd0);  chk_out("mis_24", 1'b1, 32'h24);

    exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    cyc(1'b0, 1'b1, 32'hFFFF_FFF8); chk_out("wrap_redir", 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 32'd0); chk_out("wrap_bubble", 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 32'd0); chk_out("wrap_f8", 1'b1, 32'hFFFF_FFF8);
    cyc(1'b0, 1'b0, 32'd0); chk_out("wrap_fc", 1'b1, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 32'd0); chk_out("wrap_0", 1'b1, 32'h0);
    cyc(1'b1, 1'b0, 32'd0); chk_out("hold_fill", 1'b1, 32'h4);
    cyc(1'b1, 1'b0, 32'd0); chk_out("hold_full", 1'b1, 32'h4);
    check_val("sb_drained_pre_rst", exp_q.size(), 32'd0);

    @(posedge clk_s);
    #1 reset_n_s = 1'b0;
    #1;
    check_val("midrst_valid", {31'd0, if_valid_s}, 32'd0);
    check_val("midrst_pc", if_pc_s, 32'd0);
    check_val("midrst_addr", imem_addr_s, 32'h0);
    @(posedge clk_s);
    #1;
    reset_n_s = 1'b1;
    stall_s   = 1'b0;
    @(negedge clk_s);
    chk_out("rerel", 1'b0, 32'd0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    cyc(1'b0, 1'b0, 32'd0); chk_out("restart0", 1'b1, 32'h0);
    cyc(1'b0, 1'b0, 32'd0); chk_out("restart4", 1'b1, 32'h4);
    cyc(1'b0, 1'b0, 32'd0); chk_out("restart8", 1'b1, 32'h8);
    check_val("sb_drained_end", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
